// File: rtl/i2c_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_scheduler
//  Description : Round-robin scheduler that hands a shared I2C byte engine to
//                one of two requesters, respecting external bus activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_scheduler #(
    parameter int IDLE_CYCLES = 8
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  cmd_valid,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [1:0]  cmd_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_nack,
    output logic        rsp_al,
    output logic        eng_valid,
    output logic [1:0]  eng_op,
    output logic [7:0]  eng_data,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic [7:0]  eng_rdata,
    input  logic        eng_nack,
    input  logic        eng_al,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        bus_busy
);

    localparam int              c_CNT_W     = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_FREE_LOAD = c_CNT_W'(IDLE_CYCLES);
    localparam logic [1:0]      c_OP_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANTED = 3'd1,
        S_ISSUE   = 3'd2,
        S_BUSY    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_scl_meta;
    logic                 r_scl_sync;
    logic                 r_sda_meta;
    logic                 r_sda_sync;
    logic                 r_sda_prev;
    logic                 r_bus_busy;
    logic [c_CNT_W-1:0]   r_free_cnt;
    logic [1:0]           r_gnt;
    logic                 r_owner;
    logic                 r_last;
    logic [1:0]           r_op;
    logic                 r_internal;
    logic                 r_eng_valid;
    logic [1:0]           r_eng_op;
    logic [7:0]           r_eng_data;
    logic [1:0]           r_rsp_valid;
    logic [7:0]           r_rsp_data;
    logic                 r_rsp_nack;
    logic                 r_rsp_al;

    logic                 w_start;
    logic                 w_stop;
    logic                 w_pick;
    logic [1:0]           w_own_op;
    logic [7:0]           w_own_data;
    logic                 w_accept;

    assign w_start    = r_scl_sync &  r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & ~r_sda_prev &  r_sda_sync;
    // Last-served requester gets the lower priority when both ask.
    assign w_pick     = (req == 2'b11) ? ~r_last : ~req[0];
    assign w_own_op   = r_owner ? cmd_op[3:2]    : cmd_op[1:0];
    assign w_own_data = r_owner ? cmd_data[15:8] : cmd_data[7:0];
    assign w_accept   = (r_state == S_GRANTED) & eng_ready & cmd_valid[r_owner];

    assign gnt        = r_gnt;
    assign cmd_ready  = ((r_state == S_GRANTED) && eng_ready) ? r_gnt : 2'b00;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_nack   = r_rsp_nack;
    assign rsp_al     = r_rsp_al;
    assign eng_valid  = r_eng_valid;
    assign eng_op     = r_eng_op;
    assign eng_data   = r_eng_data;
    assign bus_busy   = r_bus_busy;

    // Bus monitor: line synchronizers, START/STOP tracking and bus-free timer.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
            r_bus_busy <= 1'b0;
            r_free_cnt <= '0;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
            if (w_stop) begin
                r_bus_busy <= 1'b0;
            end else if (w_start) begin
                r_bus_busy <= 1'b1;
            end
            if (w_stop || (r_state == S_RELEASE)) begin
                r_free_cnt <= c_FREE_LOAD;
            end else if (r_free_cnt != '0) begin
                r_free_cnt <= r_free_cnt - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state     <= S_IDLE;
            r_gnt       <= 2'b00;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_op        <= 2'b00;
            r_internal  <= 1'b0;
            r_eng_valid <= 1'b0;
            r_eng_op    <= 2'b00;
            r_eng_data  <= 8'h00;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 8'h00;
            r_rsp_nack  <= 1'b0;
            r_rsp_al    <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 8'h00;
            r_rsp_nack  <= 1'b0;
            r_rsp_al    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((req != 2'b00) && !r_bus_busy && (r_free_cnt == '0)) begin
                        r_owner <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_state <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    // A completed handshake is honoured before a dropped request.
                    if (w_accept) begin
                        r_op        <= w_own_op;
                        r_internal  <= 1'b0;
                        r_eng_valid <= 1'b1;
                        r_eng_op    <= w_own_op;
                        r_eng_data  <= w_own_data;
                        r_state     <= S_ISSUE;
                    end else if (!req[r_owner] && eng_ready) begin
                        r_op        <= c_OP_STOP;
                        r_internal  <= 1'b1;
                        r_eng_valid <= 1'b1;
                        r_eng_op    <= c_OP_STOP;
                        r_eng_data  <= 8'h00;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_eng_valid <= 1'b0;
                    r_eng_op    <= 2'b00;
                    r_eng_data  <= 8'h00;
                    r_state     <= S_BUSY;
                end
                S_BUSY: begin
                    if (eng_al) begin
                        r_rsp_valid <= r_internal ? 2'b00 : r_gnt;
                        r_rsp_al    <= ~r_internal;
                        r_state     <= S_RELEASE;
                    end else if (eng_done) begin
                        r_rsp_valid <= r_internal ? 2'b00 : r_gnt;
                        if (!r_internal) begin
                            r_rsp_data <= eng_rdata;
                            r_rsp_nack <= eng_nack;
                        end
                        r_state <= (r_op == c_OP_STOP) ? S_RELEASE : S_GRANTED;
                    end
                end
                S_RELEASE: begin
                    r_gnt   <= 2'b00;
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_bus_scheduler
//  Description : Self-checking bench for i2c_bus_scheduler with a
//                transaction-level reference model and random sessions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_scheduler;

    localparam int IDLE_CYCLES = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  cmd_valid;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_nack;
    logic        rsp_al;
    logic        eng_valid;
    logic [1:0]  eng_op;
    logic [7:0]  eng_data;
    logic        eng_ready;
    logic        eng_done;
    logic [7:0]  eng_rdata;
    logic        eng_nack;
    logic        eng_al;
    logic        scl_i;
    logic        sda_i;
    logic        bus_busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the bus, who was served last, bus-free window.
    int m_owner = -1;
    int m_last  = 1;
    int m_free  = 0;

    i2c_bus_scheduler #(.IDLE_CYCLES(IDLE_CYCLES)) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .gnt(gnt),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_al(rsp_al), .eng_valid(eng_valid),
        .eng_op(eng_op), .eng_data(eng_data), .eng_ready(eng_ready),
        .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_nack(eng_nack),
        .eng_al(eng_al), .scl_i(scl_i), .sda_i(sda_i), .bus_busy(bus_busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - m_last;
        return r[0] ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
        if (m_free > 0) m_free--;
        if (rsp_valid == 2'b00) chk("rsp_idle_zero", 32'({rsp_data, rsp_nack, rsp_al}), 32'd0);
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_data, rsp_nack, rsp_al}), 32'd0);
        chk({tag, "_eng"}, 32'({eng_valid, eng_op, eng_data}), 32'd0);
        chk({tag, "_bus_busy"}, 32'(bus_busy), 32'd0);
    endtask

    // Grant appears once the bus-free window has elapsed, never earlier.
    task automatic expect_grant(input int w);
        int guard;
        guard = 0;
        while (m_free != 0 && guard < 64) begin
            tick();
            chk("gnt_wait_free", 32'(gnt), 32'd0);
            guard++;
        end
        tick();
        chk("gnt_winner", 32'(gnt), 32'(onehot(w)));
        m_owner = w;
    endtask

    task automatic release_check();
        tick();
        chk("gnt_released", 32'(gnt), 32'd0);
        chk("eng_idle_release", 32'(eng_valid), 32'd0);
        m_last    = m_owner;
        m_owner   = -1;
        m_free    = IDLE_CYCLES;
        eng_ready = 1'b1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input int stall,
                           input int lat, input bit al, input bit done,
                           input logic [7:0] rdata, input bit nack);
        logic [1:0] g1;
        logic [1:0] nz;
        logic [1:0] nv;
        logic [7:0] nd;
        g1 = onehot(m_owner);
        nz = 2'($urandom_range(0, 3));
        nv = 2'($urandom_range(0, 3));
        nd = 8'($urandom_range(0, 255));
        cmd_valid = g1 | (nv & ~g1);
        cmd_op    = (m_owner == 1) ? {op, nz} : {nz, op};
        cmd_data  = (m_owner == 1) ? {data, nd} : {nd, data};
        eng_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("cmd_ready_stall", 32'(cmd_ready), 32'd0);
            tick();
            chk("eng_valid_stall", 32'(eng_valid), 32'd0);
        end
        eng_ready = 1'b1;
        #1;
        chk("cmd_ready_owner", 32'(cmd_ready), 32'(g1));
        tick();
        chk("eng_valid_issue", 32'(eng_valid), 32'd1);
        chk("eng_op", 32'(eng_op), 32'(op));
        chk("eng_data", 32'(eng_data), 32'(data));
        cmd_valid = 2'b00;
        eng_ready = 1'b0;
        tick();
        chk("eng_valid_one_cycle", 32'(eng_valid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("rsp_early", 32'(rsp_valid), 32'd0);
        end
        eng_done  = done;
        eng_al    = al;
        eng_rdata = rdata;
        eng_nack  = nack;
        tick();
        eng_done  = 1'b0;
        eng_al    = 1'b0;
        eng_rdata = 8'($urandom_range(0, 255));
        eng_nack  = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(g1));
        chk("rsp_al", 32'(rsp_al), al ? 32'd1 : 32'd0);
        chk("rsp_data", 32'(rsp_data), al ? 32'd0 : 32'(rdata));
        if (!al) chk("rsp_nack", 32'(rsp_nack), 32'(nack));
        chk("gnt_held", 32'(gnt), 32'(g1));
        if (al || op == 2'b11) release_check();
        else eng_ready = 1'b1;
    endtask

    task automatic drop_req(input int lat);
        logic [1:0] g1;
        g1 = onehot(m_owner);
        req[m_owner] = 1'b0;
        cmd_valid = 2'b00;
        eng_ready = 1'b1;
        tick();
        chk("drop_eng_valid", 32'(eng_valid), 32'd1);
        chk("drop_eng_op", 32'(eng_op), 32'd3);
        eng_ready = 1'b0;
        tick();
        chk("drop_eng_valid_end", 32'(eng_valid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("drop_no_rsp_wait", 32'(rsp_valid), 32'd0);
        end
        eng_done  = 1'b1;
        eng_rdata = 8'($urandom_range(0, 255));
        eng_nack  = 1'($urandom_range(0, 1));
        tick();
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
        chk("drop_gnt_held", 32'(gnt), 32'(g1));
        release_check();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        logic [1:0] r;
        logic [1:0] op;
        int         idle;
        int         ncmd;
        bit         al;
        bit         lost;
        int         guard;

        presetn = 1'b0; req = 2'b00; cmd_valid = 2'b00; cmd_op = 4'h0; cmd_data = 16'h0;
        eng_ready = 1'b1; eng_done = 1'b0; eng_rdata = 8'h00; eng_nack = 1'b0; eng_al = 1'b0;
        scl_i = 1'b1; sda_i = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        presetn = 1'b1;
        m_free = 0; m_last = 1; m_owner = -1;

        // Both request after reset: requester 0 first, then 1 after the gap.
        req = 2'b11;
        expect_grant(pick(req));
        chk("first_grant_is_0", 32'(gnt), 32'd1);
        run_cmd(2'b00, 8'h00, 0, 1, 1'b0, 1'b1, 8'h00, 1'b0);
        run_cmd(2'b01, 8'hA5, 1, 2, 1'b0, 1'b1, 8'h00, 1'b0);
        run_cmd(2'b11, 8'h00, 0, 0, 1'b0, 1'b1, 8'h00, 1'b0);
        expect_grant(pick(req));
        chk("second_grant_is_1", 32'(gnt), 32'd2);

        drop_req(1);

        expect_grant(pick(req));
        run_cmd(2'b10, 8'h00, 0, 2, 1'b0, 1'b1, 8'h3C, 1'b1);
        run_cmd(2'b01, 8'h5A, 0, 1, 1'b1, 1'b1, 8'hFF, 1'b0);

        // External master holds the bus.
        req = 2'b00;
        sda_i = 1'b0;
        guard = 0;
        while (!bus_busy && guard < 8) begin tick(); guard++; end
        chk("ext_busy_rise", 32'(bus_busy), 32'd1);
        req = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ext_no_grant", 32'(gnt), 32'd0);
        end
        sda_i = 1'b1;
        guard = 0;
        while (bus_busy && guard < 8) begin
            tick();
            chk("ext_no_grant_stop", 32'(gnt), 32'd0);
            guard++;
        end
        chk("ext_busy_fall", 32'(bus_busy), 32'd0);
        m_free = IDLE_CYCLES;
        expect_grant(0);

        // Reset while the engine is busy abandons the transaction.
        cmd_valid = 2'b01; cmd_op = 4'b0001; cmd_data = 16'h00C3; eng_ready = 1'b1;
        tick();
        chk("rst_pre_issue", 32'(eng_valid), 32'd1);
        cmd_valid = 2'b00; eng_ready = 1'b0;
        tick();
        presetn = 1'b0; req = 2'b00;
        tick();
        check_all_zero("mid_reset");
        presetn = 1'b1; eng_ready = 1'b1;
        m_free = 0; m_last = 1; m_owner = -1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_quiet", 32'({gnt, rsp_valid, eng_valid}), 32'd0);
        end
        req = 2'b11;
        expect_grant(pick(req));
        run_cmd(2'b11, 8'h00, 0, 0, 1'b0, 1'b1, 8'h00, 1'b0);

        for (int s = 0; s < 40; s++) begin
            idle = $urandom_range(0, 12);
            r    = 2'($urandom_range(1, 3));
            req  = 2'b00;
            for (int i = 0; i < idle; i++) begin
                tick();
                chk("idle_no_grant", 32'(gnt), 32'd0);
            end
            req = r;
            expect_grant(pick(r));
            ncmd = $urandom_range(0, 3);
            lost = 1'b0;
            for (int c = 0; c < ncmd && !lost; c++) begin
                op = 2'($urandom_range(0, 2));
                al = ($urandom_range(0, 7) == 0);
                run_cmd(op, 8'($urandom_range(0, 255)), $urandom_range(0, 2), $urandom_range(0, 3),
                        al, al ? 1'($urandom_range(0, 1)) : 1'b1,
                        8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                if (al) lost = 1'b1;
            end
            if (!lost) begin
                if ($urandom_range(0, 1) == 1)
                    run_cmd(2'b11, 8'($urandom_range(0, 255)), $urandom_range(0, 2), $urandom_range(0, 3),
                            1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                else
                    drop_req($urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_bus_scheduler.md
I2C_BUS_SCHEDULER -- requirements
Module: i2c_bus_scheduler

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 8: bus-free cycles required after any STOP before a new grant.
REQ-002 SHALL have port pclk  in  1: single clock; all state on rising edge.
REQ-003 SHALL have port presetn  in  1: synchronous, active-low reset.
REQ-004 SHALL have port req  in  2: per-requester transaction request, bit i = requester i.
REQ-005 SHALL have port gnt  out  2: one-hot-or-zero grant.
REQ-006 SHALL have port cmd_valid  in  2: per-requester command valid.
REQ-007 SHALL have port cmd_op  in  4: {op1,op0}, 2 bits each; encoding 00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-008 SHALL have port cmd_data  in  16: {data1,data0}, write byte per requester.
REQ-009 SHALL have port cmd_ready  out  2: command accepted when valid&ready.
REQ-010 SHALL have port rsp_valid  out  2: one-cycle response pulse to the owning requester.
REQ-011 SHALL have ports rsp_data (out, 8), rsp_nack (out, 1) and rsp_al (out, 1): shared response payload; read byte, NACK received, arbitration lost.
REQ-012 SHALL have ports eng_valid (out, 1), eng_op (out, 2) and eng_data (out, 8): command to the shared I2C byte engine.
REQ-013 SHALL have ports eng_ready (in, 1) and eng_done (in, 1): engine idle, and one-cycle completion pulse.
REQ-014 SHALL have ports eng_rdata (in, 8), eng_nack (in, 1) and eng_al (in, 1): engine result; eng_al is a one-cycle arbitration-lost pulse.
REQ-015 SHALL have ports scl_i (in, 1) and sda_i (in, 1): raw samples of the shared wired-AND SCL/SDA lines.
REQ-016 SHALL have port bus_busy  out  1: bus held by any master.

Function
REQ-017 SHALL pass scl_i and sda_i through 2-flop synchronizers before any use.
REQ-018 SHALL detect START as synced SDA 1->0 while synced SCL=1, and STOP as synced SDA 0->1 while synced SCL=1.
REQ-019 SHALL set bus_busy on START and clear it on STOP; STOP wins on the same cycle.
REQ-020 SHALL load free_cnt with IDLE_CYCLES on detected STOP and on RELEASE, and decrement it to 0 with saturation.
REQ-021 SHALL implement FSM states IDLE, GRANTED, ISSUE, BUSY, RELEASE.
REQ-022 SHALL, in IDLE with req!=0, bus_busy=0 and free_cnt=0, select a requester round-robin, with last-served priority lowest; the selected gnt bit asserts on the next cycle and the state becomes GRANTED.
REQ-023 SHALL, when both requesters request after reset, grant requester 0 first.
REQ-024 SHALL, in GRANTED, drive cmd_ready[g]=eng_ready and cmd_ready of the non-owner=0 at all times.
REQ-025 SHALL, on cmd_valid[g]&cmd_ready[g], register op/data and enter ISSUE.
REQ-026 SHALL, in ISSUE, hold eng_valid=1 for exactly one cycle with the registered op/data, then enter BUSY.
REQ-027 SHALL, in BUSY on eng_done, pulse rsp_valid[g] with rsp_data=eng_rdata, rsp_nack=eng_nack and rsp_al=0.
REQ-028 SHALL, on that eng_done, go to RELEASE if the op was STOP and to GRANTED otherwise.
REQ-029 SHALL, on eng_al in BUSY, pulse rsp_valid[g] with rsp_al=1 and rsp_data=0 and go to RELEASE; eng_al takes precedence over a simultaneous eng_done.
REQ-030 SHALL, if req[g] drops in GRANTED, issue an internal STOP via ISSUE/BUSY and suppress its rsp_valid.
REQ-031 SHALL, in RELEASE, clear gnt, record g as last-served and return to IDLE next cycle; gnt therefore stays stable from grant to RELEASE.
REQ-032 SHALL ignore cmd_valid from a non-owner, which never reaches the engine.
REQ-033 SHALL hold rsp_data, rsp_nack and rsp_al at 0 whenever rsp_valid=0.

Reset
REQ-034 SHALL, when presetn=0 at a clock edge, force IDLE; gnt, cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_al, eng_valid, eng_op, eng_data and bus_busy =0; free_cnt=0; last-served=1; synchronizers=1.
REQ-035 SHALL, on reset mid-transaction, abandon it with no response and no STOP issued.

Verification
REQ-036 Bench SHALL cover: req=11 after reset -> gnt=01; requester 0 runs START/WRITE 0xA5/STOP with an IDLE_CYCLES=8 gap -> gnt=10.
REQ-037 Bench SHALL cover: owner0 READ with engine returning 0x3C, eng_nack=1 -> rsp_valid=01, rsp_data=0x3C, rsp_nack=1 on the cycle after eng_done.
REQ-038 Bench SHALL cover: external START on scl_i/sda_i with req=01 -> no grant until STOP plus 8 idle cycles, bus_busy 1->0 on STOP.
REQ-039 Bench SHALL cover: eng_al and eng_done in the same cycle during WRITE -> rsp_al=1, rsp_data=0x00, gnt=00 two cycles later.
REQ-040 Bench SHALL cover: owner drops req in GRANTED -> eng_valid with eng_op=11, no rsp_valid, then RELEASE.
REQ-041 Bench SHALL cover: presetn=0 during BUSY -> all outputs 0 on the next cycle, state IDLE.
